// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement sequencer: FSM state encoding,
// derived width functions and the thermometer-code cleanliness test.
package tdc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_LAUNCH,
      ST_SETTLE,
      ST_SAMPLE,
      ST_ACCUM,
      ST_DONE
   } tdc_state_e;

   // Widest thermometer the cleanliness helper accepts; narrower codes are zero-extended.
   localparam int THERM_MAX_W = 1024;

   function automatic int code_w(input int data_width);
      return $clog2(data_width + 1);
   endfunction

   function automatic int sum_w(input int cw, input int cnt_w);
      return cw + cnt_w;
   endfunction

   // A clean thermometer is a run of ones from the LSB: adding one carries through
   // the whole run, so nothing survives the AND. Zero-extension keeps this true.
   function automatic logic therm_is_clean(input logic [THERM_MAX_W-1:0] x);
      logic [THERM_MAX_W-1:0] x_inc;
      x_inc = x + {{(THERM_MAX_W-1){1'b0}}, 1'b1};
      return (x & x_inc) == '0;
   endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Combinational thermometer decoder: popcount of the sampled TDC word plus a
// bubble flag raised when the word is not a contiguous run of ones from the LSB.
module tdc_therm_decode
   import tdc_pkg::*;
#(
   parameter  int DATA_WIDTH = 252,
   localparam int CODE_W     = code_w(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] therm,
   output logic [CODE_W-1:0]     code,
   output logic                  bubble
);

   always_comb begin
      code = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         code = code + CODE_W'(therm[i]);
      end
      bubble = !therm_is_clean(THERM_MAX_W'(therm));
   end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the SRAM22 TDC macro: per sample resets the TDC, fires one
// launch edge, waits for settling, samples and decodes, and accumulates run statistics.
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter  int DATA_WIDTH    = 252,
   parameter  int SETTLE_CYCLES = 4,
   parameter  int CNT_W         = 8,
   localparam int CODE_W        = code_w(DATA_WIDTH),
   localparam int SUM_W         = sum_w(CODE_W, CNT_W)
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CNT_W-1:0]      samples_m1,
   input  logic                  continuous,
   output logic                  tdc_reset_b,
   output logic                  tdc_launch,
   input  logic [DATA_WIDTH-1:0] tdc_dout,
   output logic                  busy,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [SUM_W-1:0]      res_sum,
   output logic [CODE_W-1:0]     res_min,
   output logic [CODE_W-1:0]     res_max,
   output logic                  res_bubble
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

   tdc_state_e              state_q, state_d;
   logic [SET_W-1:0]        settle_cnt_q;
   logic [CNT_W-1:0]        sample_cnt_q;
   logic [CNT_W-1:0]        samples_m1_q;
   logic                    cont_q;
   logic [DATA_WIDTH-1:0]   therm_p1;
   logic [CODE_W-1:0]       code_p1;
   logic                    bubble_p1;
   logic                    settle_done;
   logic                    last_sample;
   logic                    handshake;
   logic                    run_clear;

   assign settle_done = (settle_cnt_q == SET_LAST);
   assign last_sample = (sample_cnt_q == samples_m1_q);
   assign handshake   = (state_q == ST_DONE) && res_ready;
   // Statistics restart on an accepted start and on every continuous-mode re-arm.
   assign run_clear   = !abort && (((state_q == ST_IDLE) && start) || (handshake && cont_q));

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      busy        = (state_q != ST_IDLE);
      res_valid   = (state_q == ST_DONE);
      tdc_launch  = (state_q == ST_LAUNCH);
      tdc_reset_b = 1'b0;
      unique case (state_q)
         ST_IDLE:   if (start) state_d = ST_ARM;
         ST_ARM:    state_d = ST_LAUNCH;
         ST_LAUNCH: begin
            tdc_reset_b = 1'b1;
            state_d     = ST_SETTLE;
         end
         ST_SETTLE: begin
            tdc_reset_b = 1'b1;
            if (settle_done) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            tdc_reset_b = 1'b1;
            state_d     = ST_ACCUM;
         end
         ST_ACCUM: begin
            tdc_reset_b = 1'b1;
            state_d     = last_sample ? ST_DONE : ST_ARM;
         end
         ST_DONE:   if (res_ready) state_d = cont_q ? ST_ARM : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         settle_cnt_q <= '0;
         sample_cnt_q <= '0;
         samples_m1_q <= '0;
         cont_q       <= 1'b0;
      end else begin
         settle_cnt_q <= ((state_q == ST_SETTLE) && !settle_done) ? settle_cnt_q + 1'b1 : '0;
         if ((state_q == ST_IDLE) && start && !abort) begin
            samples_m1_q <= samples_m1;
            cont_q       <= continuous;
         end
         if (run_clear) begin
            sample_cnt_q <= '0;
         end else if ((state_q == ST_ACCUM) && !last_sample) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
         end
      end
   end

   // Stage p1: TDC word captured in SAMPLE, decoded combinationally for ACCUM.
   always_ff @(posedge clk) begin
      if (state_q == ST_SAMPLE) therm_p1 <= tdc_dout;
   end

   tdc_therm_decode #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_decode (
      .therm  (therm_p1),
      .code   (code_p1),
      .bubble (bubble_p1)
   );

   // Stage p2: statistics accumulate in ACCUM.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         res_sum    <= '0;
         res_min    <= '1;
         res_max    <= '0;
         res_bubble <= 1'b0;
      end else if (run_clear) begin
         res_sum    <= '0;
         res_min    <= '1;
         res_max    <= '0;
         res_bubble <= 1'b0;
      end else if (state_q == ST_ACCUM) begin
         res_sum    <= res_sum + SUM_W'(code_p1);
         if (code_p1 < res_min) res_min <= code_p1;
         if (code_p1 > res_max) res_max <= code_p1;
         res_bubble <= res_bubble | bubble_p1;
      end
   end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl: TDC words are queued per launch, expected
// statistics are queued per run and compared when res_valid appears.
module tb_tdc_meas_ctrl;

   localparam int DW     = 252;
   localparam int S      = 4;
   localparam int CW     = 8;
   localparam int CODE_W = 8;
   localparam int SUM_W  = 16;

   typedef struct {
      logic [SUM_W-1:0]  sum;
      logic [CODE_W-1:0] mn;
      logic [CODE_W-1:0] mx;
      logic              bub;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_b;
   logic              start;
   logic              abort;
   logic [CW-1:0]     samples_m1;
   logic              continuous;
   logic              tdc_reset_b;
   logic              tdc_launch;
   logic [DW-1:0]     tdc_dout;
   logic              busy;
   logic              res_valid;
   logic              res_ready;
   logic [SUM_W-1:0]  res_sum;
   logic [CODE_W-1:0] res_min;
   logic [CODE_W-1:0] res_max;
   logic              res_bubble;

   exp_t          exp_q[$];
   logic [DW-1:0] pat_q[$];
   int            checks     = 0;
   int            failures   = 0;
   int            launch_cnt = 0;

   tdc_meas_ctrl #(
      .DATA_WIDTH    (DW),
      .SETTLE_CYCLES (S),
      .CNT_W         (CW)
   ) dut (
      .clk         (clk),
      .reset_b     (reset_b),
      .start       (start),
      .abort       (abort),
      .samples_m1  (samples_m1),
      .continuous  (continuous),
      .tdc_reset_b (tdc_reset_b),
      .tdc_launch  (tdc_launch),
      .tdc_dout    (tdc_dout),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_sum     (res_sum),
      .res_min     (res_min),
      .res_max     (res_max),
      .res_bubble  (res_bubble)
   );

   always #5 clk = ~clk;

   // TDC macro stand-in: each launch presents the next queued word well before sampling.
   always @(negedge clk) begin
      if (tdc_launch) begin
         launch_cnt++;
         if (pat_q.size() > 0) tdc_dout = pat_q.pop_front();
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, expv);
      end
   endtask

   function automatic logic [DW-1:0] therm(input int n);
      logic [DW:0] t;
      t = ({{DW{1'b0}}, 1'b1} << n) - 1'b1;
      return t[DW-1:0];
   endfunction

   function automatic exp_t model(input int off, input int n);
      exp_t e;
      int   c;
      e.sum = '0;
      e.mn  = '1;
      e.mx  = '0;
      e.bub = 1'b0;
      for (int i = off; i < off + n; i++) begin
         c = $countones(pat_q[i]);
         e.sum = e.sum + SUM_W'(c);
         if (CODE_W'(c) < e.mn) e.mn = CODE_W'(c);
         if (CODE_W'(c) > e.mx) e.mx = CODE_W'(c);
         if (pat_q[i] != therm(c)) e.bub = 1'b1;
      end
      return e;
   endfunction

   task automatic start_run(input int n_m1, input bit cont);
      @(negedge clk);
      samples_m1 = n_m1[CW-1:0];
      continuous = cont;
      start      = 1'b1;
   endtask

   // cyc0=0: called right after start_run; cyc0=1: DUT already observed in ARM.
   task automatic wait_result(input int n, input int cyc0, input int hold,
                              input bit cont_exp, input int restart_at);
      int   cyc;
      bit   got;
      exp_t e;
      cyc        = cyc0;
      got        = 1'b0;
      launch_cnt = 0;
      while (cyc < 4000 && !got) begin
         @(negedge clk);
         cyc++;
         start      = 1'b0;
         continuous = 1'b0;
         if (cyc == restart_at) begin
            start      = 1'b1;
            samples_m1 = '0;
         end
         if (cyc0 == 0 && cyc == 1) chk("arm_state", 64'({busy, tdc_reset_b, tdc_launch}), 64'(3'b100));
         if (cyc0 == 0 && cyc == 2) chk("launch_state", 64'({tdc_reset_b, tdc_launch}), 64'(2'b11));
         if (cyc0 == 0 && cyc == 3) chk("launch_pulse", 64'(tdc_launch), 64'(0));
         if (res_valid) got = 1'b1;
      end
      chk("result_seen", 64'(got), 64'(1));
      chk("latency", 64'(cyc), 64'(n * (S + 4) + 1));
      chk("launches", 64'(launch_cnt), 64'(n));
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 64'(0), 64'(1));
         e = '{sum: '0, mn: '1, mx: '0, bub: 1'b0};
      end else begin
         e = exp_q.pop_front();
      end
      chk("res_sum", 64'(res_sum), 64'(e.sum));
      chk("res_min", 64'(res_min), 64'(e.mn));
      chk("res_max", 64'(res_max), 64'(e.mx));
      chk("res_bubble", 64'(res_bubble), 64'(e.bub));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 64'(res_valid), 64'(1));
         chk("hold_sum", 64'(res_sum), 64'(e.sum));
         chk("hold_minmax", 64'({res_min, res_max}), 64'({e.mn, e.mx}));
         chk("hold_bubble", 64'(res_bubble), 64'(e.bub));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (cont_exp) begin
         chk("cont_rearm", 64'({busy, tdc_reset_b, res_valid}), 64'(3'b100));
         chk("cont_clear", 64'({res_sum, res_min, res_max, res_bubble}),
             64'({16'h0, 8'hff, 8'h00, 1'b0}));
      end else begin
         chk("idle_after", 64'({busy, res_valid}), 64'(2'b00));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk(tag, 64'({busy, res_valid, tdc_reset_b, tdc_launch}), 64'(4'b0000));
      chk({tag, "_res"}, 64'({res_sum, res_min, res_max, res_bubble}),
          64'({16'h0, 8'hff, 8'h00, 1'b0}));
   endtask

   initial begin
      int seen;
      reset_b    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      samples_m1 = '0;
      continuous = 1'b0;
      res_ready  = 1'b0;
      tdc_dout   = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset_b = 1'b1;
      @(negedge clk);
      chk_reset_vals("post_reset");

      // Single sample, four ones.
      pat_q.push_back(DW'(8'h0F));
      exp_q.push_back(model(0, 1));
      start_run(0, 0);
      wait_result(1, 0, 0, 0, -1);

      // Four samples; a second start mid-run must be ignored.
      pat_q.push_back(therm(10)); pat_q.push_back(therm(12));
      pat_q.push_back(therm(11)); pat_q.push_back(therm(13));
      exp_q.push_back(model(0, 4));
      start_run(3, 0);
      wait_result(4, 0, 0, 0, 5);

      // Bubble word alone, then sticky bubble across a clean sample.
      pat_q.push_back(DW'(4'b1011));
      exp_q.push_back(model(0, 1));
      start_run(0, 0);
      wait_result(1, 0, 0, 0, -1);
      pat_q.push_back(therm(5)); pat_q.push_back(DW'(4'b1011));
      exp_q.push_back(model(0, 2));
      start_run(1, 0);
      wait_result(2, 0, 0, 0, -1);

      // Back-pressure in DONE, then continuous re-arm twice, then abort.
      pat_q.push_back(therm(7)); pat_q.push_back(therm(200));
      exp_q.push_back(model(0, 1));
      exp_q.push_back(model(1, 1));
      start_run(0, 1);
      wait_result(1, 0, 10, 1, -1);
      wait_result(1, 1, 0, 1, -1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_in_arm", 64'({busy, res_valid, tdc_reset_b}), 64'(3'b000));

      // Abort during SETTLE.
      pat_q.push_back(therm(20));
      start_run(0, 0);
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_settle", 64'({busy, res_valid, tdc_reset_b}), 64'(3'b000));
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid || busy) seen++;
      end
      chk("abort_quiet", 64'(seen), 64'(0));

      // Abort wins over start in IDLE.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_wins", 64'(busy), 64'(0));

      // Asynchronous reset after the first of four samples accumulates.
      pat_q.delete();
      pat_q.push_back(therm(10)); pat_q.push_back(therm(12));
      pat_q.push_back(therm(11)); pat_q.push_back(therm(13));
      start_run(3, 0);
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("mid_sum", 64'(res_sum), 64'(10));
      reset_b = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      @(negedge clk);
      reset_b = 1'b1;
      pat_q.delete();
      @(negedge clk);
      chk_reset_vals("after_async_reset");

      // Full-scale run: 256 all-ones samples.
      for (int i = 0; i < 256; i++) pat_q.push_back(therm(DW));
      exp_q.push_back(model(0, 256));
      start_run(255, 0);
      wait_result(256, 0, 2, 0, -1);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
